// File: rtl/eprisc_serial_pkg.sv
// Shared types and constants for the eprisc serial receive and transmit paths.
package eprisc_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    typedef logic [7:0] serial_byte_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Even parity: flags a frame whose data plus parity bit carries an odd number of ones.
    function automatic logic parity_mismatch(input serial_byte_t data, input logic parity_bit);
        return (^data) ^ parity_bit;
    endfunction

endpackage

// File: rtl/eprisc_serial_fifo.sv
// First-word-fall-through FIFO shared by the serial RX and TX paths.
module eprisc_serial_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        empty     = (count_r == {CW{1'b0}});
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= push_ok_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
            rd_ptr_r <= pop_ok_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
            count_r  <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/eprisc_serial_receiver.sv
// Serial receiver: synchroniser, 8N1 frame FSM, FWFT byte FIFO and sticky error flags.
// Build option EPRISC_SERIALRX_PARITY_EN switches to 8E1 frames with parity checking.
module eprisc_serial_receiver
    import eprisc_serial_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 256,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic       iBoardClock,
    input  logic       iBoardReset,
    input  logic       iSerialRX,
    output logic [7:0] oRxData,
    output logic       oRxValid,
    input  logic       iRxReady,
    output logic       oRxBusy,
    output logic       oRxFramingError,
    output logic       oRxOverflow,
    output logic       oRxParityError,
    input  logic       iRxClearErrors
);
    localparam int TIMER_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(CLOCKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
`ifdef EPRISC_SERIALRX_PARITY_EN
    localparam rx_state_t AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_t AFTER_DATA = ST_STOP;
`endif

    logic [1:0]         sync_r;
    logic               rx_s;
    logic               line_idle_s;
    rx_state_t          state_r;
    rx_state_t          state_next_s;
    logic [TIMER_W-1:0] timer_r;
    logic               expire_s;
    logic [2:0]         bit_cnt_r;
    serial_byte_t       shift_r;
    logic               load_half_s;
    logic               load_full_s;
    logic               shift_en_s;
    logic               push_s;
    logic               pop_s;
    logic               framing_evt_s;
    logic               overflow_evt_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               framing_r;
    logic               overflow_r;
`ifdef EPRISC_SERIALRX_PARITY_EN
    logic               parity_evt_s;
    logic               parity_bad_r;
    logic               parity_r;
`endif

    assign rx_s        = sync_r[1];
    assign line_idle_s = (rx_s == IDLE_LEVEL);
    assign expire_s    = (timer_r == {TIMER_W{1'b0}});

    // Two-flop synchroniser on the raw RX pin.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            sync_r <= {2{IDLE_LEVEL}};
        end else begin
            sync_r <= {sync_r[0], iSerialRX};
        end
    end

    // FSM state register.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:      state_next_s = line_idle_s ? ST_IDLE : ST_START;
            ST_START:     state_next_s = !expire_s ? ST_START : (line_idle_s ? ST_IDLE : ST_DATA);
            ST_DATA:      state_next_s = (expire_s && bit_cnt_r == 3'd7) ? AFTER_DATA : ST_DATA;
`ifdef EPRISC_SERIALRX_PARITY_EN
            ST_PARITY:    state_next_s = expire_s ? ST_STOP : ST_PARITY;
`endif
            ST_STOP:      state_next_s = !expire_s ? ST_STOP : (line_idle_s ? ST_IDLE : ST_WAIT_IDLE);
            ST_WAIT_IDLE: state_next_s = line_idle_s ? ST_IDLE : ST_WAIT_IDLE;
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: timer loads, shift strobes, FIFO push and error events.
    always_comb begin
        load_half_s   = 1'b0;
        load_full_s   = 1'b0;
        shift_en_s    = 1'b0;
        push_s        = 1'b0;
        framing_evt_s = 1'b0;
`ifdef EPRISC_SERIALRX_PARITY_EN
        parity_evt_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE:  load_half_s = !line_idle_s;
            ST_START: load_full_s = expire_s && !line_idle_s;
            ST_DATA: begin
                shift_en_s  = expire_s;
                load_full_s = expire_s;
            end
`ifdef EPRISC_SERIALRX_PARITY_EN
            ST_PARITY: begin
                load_full_s  = expire_s;
                parity_evt_s = expire_s && parity_mismatch(shift_r, rx_s);
            end
`endif
            ST_STOP: begin
`ifdef EPRISC_SERIALRX_PARITY_EN
                push_s = expire_s && line_idle_s && !parity_bad_r;
`else
                push_s = expire_s && line_idle_s;
`endif
                framing_evt_s = expire_s && !line_idle_s;
            end
            default: push_s = 1'b0;
        endcase
    end

    // Bit timer, bit counter and LSB-first shift register.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            timer_r   <= {TIMER_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            if (load_half_s) begin
                timer_r <= HALF_LOAD;
            end else if (load_full_s) begin
                timer_r <= FULL_LOAD;
            end else if (!expire_s) begin
                timer_r <= timer_r - TIMER_ONE;
            end else begin
                timer_r <= timer_r;
            end
            if (load_half_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            shift_r <= shift_en_s ? {rx_s, shift_r[7:1]} : shift_r;
        end
    end

    assign pop_s          = iRxReady && !fifo_empty_s;
    assign overflow_evt_s = push_s && fifo_full_s && !pop_s;

    eprisc_serial_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (iBoardClock),
        .reset     (iBoardReset),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .head      (oRxData),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            framing_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            framing_r  <= (framing_r && !iRxClearErrors) || framing_evt_s;
            overflow_r <= (overflow_r && !iRxClearErrors) || overflow_evt_s;
        end
    end

`ifdef EPRISC_SERIALRX_PARITY_EN
    // Parity result of the current frame and its sticky flag.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            parity_bad_r <= 1'b0;
            parity_r     <= 1'b0;
        end else begin
            parity_bad_r <= load_half_s ? 1'b0 : (parity_bad_r || parity_evt_s);
            parity_r     <= (parity_r && !iRxClearErrors) || parity_evt_s;
        end
    end
    assign oRxParityError = parity_r;
`else
    assign oRxParityError = 1'b0;
`endif

    assign oRxValid        = !fifo_empty_s;
    assign oRxBusy         = (state_r != ST_IDLE);
    assign oRxFramingError = framing_r;
    assign oRxOverflow     = overflow_r;

endmodule

// File: doc/eprisc_serial_receiver.md
# eprisc_serial_receiver

Asynchronous TTL serial receiver that sits directly upstream of the I/O controller's serial path. It synchronises the raw RX pin, recovers 8N1 frames at a fixed clock-derived bit rate and buffers received bytes in a small FIFO. The I/O controller drains the FIFO through a valid/ready port. Error conditions are reported as sticky flags.

## Interface
- CLOCKS_PER_BIT, 256, board clocks per serial bit; even, ≥ 8
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2–64
- iBoardClock  input  1  board clock; all logic on rising edge
- iBoardReset  input  1  synchronous, active-high reset
- iSerialRX  input  1  raw asynchronous RX line; idle high
- oRxData  output  8  FIFO head byte; valid while oRxValid
- oRxValid  output  1  FIFO non-empty
- iRxReady  input  1  consumer accepts head when oRxValid && iRxReady
- oRxBusy  output  1  frame in progress (state ≠ IDLE)
- oRxFramingError  output  1  sticky; stop bit sampled low
- oRxOverflow  output  1  sticky; byte arrived with FIFO full
- oRxParityError  output  1  sticky parity mismatch (see Configuration)
- iRxClearErrors  input  1  one-cycle pulse clears all sticky flags

## Operation
- 2-flop synchroniser on iSerialRX, both flops reset to 1; the rest of the block sees only the synchronised bit `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE: `rx_s` = 0 → START, bit counter cleared, timer loaded with CLOCKS_PER_BIT/2 − 1.
- START: timer expires, then sample. `rx_s` = 1 → false start, back to IDLE, nothing recorded. `rx_s` = 0 → DATA, timer = CLOCKS_PER_BIT − 1.
- DATA: sample at each expiry and shift into the shift register LSB-first. After 8 samples → PARITY or STOP.
- STOP: sample at expiry.
  - `rx_s` = 1: push the byte and go to IDLE.
  - `rx_s` = 0: set oRxFramingError, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s` = 1, then IDLE. This prevents a break condition being decoded as 0x00 frames.
- FIFO is first-word-fall-through. oRxData is always the head entry.
- Pop happens when oRxValid && iRxReady.
- Push when full sets oRxOverflow and drops the new byte. FIFO contents are unchanged.
- Push and pop in the same cycle on a full FIFO: both succeed, no overflow.
- iRxClearErrors together with a new error event in the same cycle: the flag ends set.

## Timing
- Reset values:
  - oRxValid, oRxBusy, all error flags = 0.
  - oRxData = 0x00.
  - FIFO empty, FSM in IDLE, synchroniser = 1.
- Reset mid-frame: abort the frame and flush the FIFO in the same cycle. No partial byte is ever pushed.
- Input latency: pin edge to `rx_s` is 2 cycles.
- Sample points, with t0 = first cycle `rx_s` = 0:
  - Start bit: t0 + CLOCKS_PER_BIT/2.
  - Data bit n: t0 + CLOCKS_PER_BIT/2 + (n+1)·CLOCKS_PER_BIT.
  - Stop bit: t0 + CLOCKS_PER_BIT/2 + 9·CLOCKS_PER_BIT.
- oRxValid rises exactly 1 cycle after the stop-bit sample when the FIFO was empty.
- A pop updates oRxData/oRxValid on the next edge. The consumer can pop back-to-back, one byte per cycle.
- oRxBusy falls in the cycle the FSM returns to IDLE. A new start bit is accepted on the following cycle.

## Configuration
- EPRISC_SERIALRX_PARITY_EN defined:
  - Frames are 8E1 and the PARITY state is included.
  - The parity bit is sampled CLOCKS_PER_BIT after data bit 7.
  - On a mismatch, oRxParityError is set and the byte is discarded.
  - The stop bit is still checked.
- Macro undefined:
  - Frames are 8N1 and there is no PARITY state.
  - oRxParityError is tied to 0.

## Structure
- Package `eprisc_serial_pkg` holds:
  - the FSM state enum;
  - the 8-bit `serial_byte_t` typedef;
  - the idle-level constant.
- One sub-module: `eprisc_serial_fifo`, a parameterised FWFT FIFO with push/pop/full/empty. It is reused later for the TX path.
- Timer width is $clog2(CLOCKS_PER_BIT). Count width is $clog2(FIFO_DEPTH)+1.

## Test plan
- Reset release, line idle for 1000 cycles → oRxValid = 0, oRxBusy = 0, no flags set.
- Four back-to-back 8N1 frames, 256 clk/bit, bytes 0x31, 0x2E, 0x41, 0x0D, iRxReady held 0 → oRxValid rises 1 cycle after the first stop sample. Then raise iRxReady → 0x31, 0x2E, 0x41, 0x0D are read on 4 consecutive cycles, then oRxValid = 0.
- 100-cycle low glitch on idle line → false start, back to IDLE, no byte pushed, no flag set.
- Frame 0x55 with the stop bit forced low, followed by a held break → oRxFramingError = 1, FIFO empty, FSM stays in WAIT_IDLE until the line goes high. iRxClearErrors then clears the flag.
- 17 frames with iRxReady = 0 and FIFO_DEPTH = 16 → oRxOverflow = 1 and the FIFO holds the first 16 bytes in order. Repeat with a pop in the same cycle as the 17th push → no overflow.
- Assert iBoardReset during data bit 4 of a frame with 3 bytes already queued → oRxValid = 0 the next cycle. The next frame after reset (0xA5) is received correctly.
